// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core widths and constants, buffer occupancy states,
//               the fetch buffer entry type and a PC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

  // The buffer's state is its occupancy; BUF_TWO exists only in the skid build.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Fetch-stage bus: instruction-memory address/data, execute
//               redirect request, and the valid/ready handoff to decode.
//               master = fetch stage, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;
  import core_pkg::*;

  logic [XLEN-1:0] o_PC;
  logic [ILEN-1:0] i_Instr;
  logic            i_Redirect;
  logic [XLEN-1:0] i_Redirect_PC;
  logic            o_Valid;
  logic [ILEN-1:0] o_Instr;
  logic [XLEN-1:0] o_Instr_PC;
  logic            i_Ready;

  modport master (
    output o_PC, o_Valid, o_Instr, o_Instr_PC,
    input  i_Instr, i_Redirect, i_Redirect_PC, i_Ready
  );

  modport slave (
    input  o_PC, o_Valid, o_Instr, o_Instr_PC,
    output i_Instr, i_Redirect, i_Redirect_PC, i_Ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : IF/ID buffer, 1 or 2 entries deep, with flush. Entry 0 is
//               always the head, so the head output needs no read mux.
//               The caller never enqueues into a full buffer and never
//               dequeues an empty one.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         i_Clock,
  input  logic         i_Reset_n,
  input  logic         i_Flush,
  input  logic         i_Enq,
  input  fetch_entry_t i_Enq_Data,
  input  logic         i_Deq,
  output logic [1:0]   o_Count,
  output fetch_entry_t o_Head
);

  buf_state_e state_q, state_d;

  // Occupancy register; reset and flush both empty the buffer.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state_q <= BUF_EMPTY;
    else            state_q <= state_d;
  end

  // Occupancy next state: flush wins, simultaneous enq+deq holds the count.
  always_comb begin
    state_d = state_q;
    if (i_Flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case ({i_Enq, i_Deq})
        2'b10:   state_d = (state_q == BUF_EMPTY) ? BUF_ONE : BUF_TWO;
        2'b01:   state_d = (state_q == BUF_TWO)   ? BUF_ONE : BUF_EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  assign o_Count = state_q;

  generate
    if (DEPTH == 2) begin : g_depth2
      fetch_entry_t ent0_q, ent1_q;

      // Two-entry shift storage: a dequeue shifts entry 1 into the head slot.
      always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
          ent0_q <= '0;
          ent1_q <= '0;
        end else if (!i_Flush) begin
          if (i_Deq) begin
            if (state_q == BUF_TWO) begin
              ent0_q <= ent1_q;
              if (i_Enq) ent1_q <= i_Enq_Data;
            end else if (i_Enq) begin
              ent0_q <= i_Enq_Data;
            end
          end else if (i_Enq) begin
            if (state_q == BUF_EMPTY) ent0_q <= i_Enq_Data;
            else                      ent1_q <= i_Enq_Data;
          end
        end
      end

      assign o_Head = ent0_q;
    end else begin : g_depth1
      fetch_entry_t ent0_q;

      // Single slot: every enqueue overwrites the head.
      always_ff @(posedge i_Clock) begin
        if (!i_Reset_n)             ent0_q <= '0;
        else if (!i_Flush && i_Enq) ent0_q <= i_Enq_Data;
      end

      assign o_Head = ent0_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch
// Description : Instruction-fetch stage. Owns the PC, reads a combinational
//               instruction memory, buffers {instr, pc} for decode and
//               handles execute redirects (which flush the buffer).
//               Build option FETCH_SKID_EN: 2-entry buffer whose enqueue
//               depends only on registered state (no i_Ready -> o_PC path).
//               Default build: 1-entry buffer, enqueue uses i_Ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic     i_Clock,
  input  logic     i_Reset_n,
  fetch_if.master  bus
);

`ifdef FETCH_SKID_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      count;
  logic            valid;
  logic            enq;
  logic            deq;
  fetch_entry_t    enq_data;
  fetch_entry_t    head;

  assign valid = (count != 2'd0);

  // A redirect flushes the head, so a coincident handshake is not a dequeue.
  assign deq = valid && bus.i_Ready && !bus.i_Redirect;

`ifdef FETCH_SKID_EN
  assign enq = !bus.i_Redirect && (count < 2'd2);
`else
  assign enq = !bus.i_Redirect && ((count == 2'd0) || bus.i_Ready);
`endif

  assign enq_data.instr = bus.i_Instr;
  assign enq_data.pc    = pc_q;

  // PC next state: redirect target beats sequential advance; stall holds.
  always_comb begin
    pc_d = pc_q;
    if (bus.i_Redirect) pc_d = align_pc(bus.i_Redirect_PC);
    else if (enq)       pc_d = pc_q + PC_STEP;
  end

  // PC register.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) pc_q <= RESET_PC;
    else            pc_q <= pc_d;
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Flush    (bus.i_Redirect),
    .i_Enq      (enq),
    .i_Enq_Data (enq_data),
    .i_Deq      (deq),
    .o_Count    (count),
    .o_Head     (head)
  );

  assign bus.o_PC       = pc_q;
  assign bus.o_Valid    = valid;
  assign bus.o_Instr    = head.instr;
  assign bus.o_Instr_PC = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch
// Description : Self-checking bench for fetch: constant vector table,
//               directed stall/redirect sequences, and random traffic
//               checked against a queue-based reference model.
//               Honours FETCH_SKID_EN for build-dependent expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;
  import core_pkg::*;

`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [63:0] TB_RESET_PC = 64'h0;

  logic clk = 1'b0;
  logic rst_n;

  fetch_if bus();

  fetch #(
    .RESET_PC (TB_RESET_PC)
  ) u_dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0070_8093;
      64'h4:   return 32'h0051_0113;
      64'h8:   return 32'h0011_01B3;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.i_Instr = mem_rd(bus.o_PC);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the buffer as a queue of {pc, instr}, plus the PC.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mpc;

  task automatic model_update(input logic rn, input logic rd,
                              input logic [63:0] rpc, input logic rdy);
    bit   v, dq, eq;
    ent_t e;
    if (!rn) begin
      mq.delete();
      mpc = TB_RESET_PC;
    end else if (rd) begin
      mq.delete();
      mpc = rpc & ~64'h3;
    end else begin
      v  = (mq.size() != 0);
      dq = v && rdy;
      eq = SKID ? (mq.size() < 2) : ((mq.size() == 0) || rdy);
      if (dq) void'(mq.pop_front());
      if (eq) begin
        e.pc    = mpc;
        e.instr = mem_rd(mpc);
        mq.push_back(e);
        mpc = mpc + 64'd4;
      end
    end
  endtask

  task automatic model_check();
    chk("model_pc", bus.o_PC, mpc);
    chk("model_valid", {63'd0, bus.o_Valid}, {63'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      chk("model_instr_pc", bus.o_Instr_PC, mq[0].pc);
      chk("model_instr", {32'd0, bus.o_Instr}, {32'd0, mq[0].instr});
    end
  endtask

  // One clock: drive inputs, advance the model, take the edge, check at negedge.
  task automatic cycle(input logic rn, input logic rd,
                       input logic [63:0] rpc, input logic rdy);
    rst_n             = rn;
    bus.i_Redirect    = rd;
    bus.i_Redirect_PC = rpc;
    bus.i_Ready       = rdy;
    #1;
    model_update(rn, rd, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        rn;
    logic        rd;
    logic [63:0] rpc;
    logic        rdy;
    logic        ev;
    logic        ezero;
    logic [63:0] epc;
    logic [63:0] eipc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [63:0] heads[3];
    logic [63:0] rpc;

    // rn rd rpc rdy | valid zero o_PC instr_pc instr
    vt[0]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0,  64'h0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h4,  64'h0, 32'h0070_8093};
    vt[2]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h8,  64'h4, 32'h0051_0113};
    vt[3]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'hC,  64'h8, 32'h0011_01B3};
    vt[4]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h10, 64'hC, 32'h0};
    vt[5]  = '{1'b1, 1'b1, 64'h7, 1'b1, 1'b0, 1'b0, 64'h4,  64'h0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h8,  64'h4, 32'h0051_0113};
    vt[7]  = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFC, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h4,  64'h0, 32'h0070_8093};
    vt[10] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h8,  64'h4, 32'h0051_0113};
    vt[11] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0,  64'h0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h4,  64'h0, 32'h0070_8093};

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].rn, vt[i].rd, vt[i].rpc, vt[i].rdy);
      chk($sformatf("vec%0d_pc", i), bus.o_PC, vt[i].epc);
      chk($sformatf("vec%0d_valid", i), {63'd0, bus.o_Valid}, {63'd0, vt[i].ev});
      if (vt[i].ev || vt[i].ezero) begin
        chk($sformatf("vec%0d_instr_pc", i), bus.o_Instr_PC, vt[i].eipc);
        chk($sformatf("vec%0d_instr", i), {32'd0, bus.o_Instr}, {32'd0, vt[i].einstr});
      end
    end

    // Stall after the first fetch, then release: order preserved, no duplicates.
    cycle(1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 64'h0, 1'b0);
    chk("stall_pc", bus.o_PC, SKID ? 64'h8 : 64'h4);
    chk("stall_valid", {63'd0, bus.o_Valid}, 64'd1);
    heads[0] = bus.o_Instr_PC;
    for (int i = 1; i < 3; i++) begin
      cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk($sformatf("release%0d_valid", i), {63'd0, bus.o_Valid}, 64'd1);
      heads[i] = bus.o_Instr_PC;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("release_order%0d", i), heads[i], 64'(4 * i));

    // Redirect with a full buffer and a coincident handshake.
    cycle(1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 64'h0, 1'b0);
    cycle(1'b1, 1'b1, 64'h4, 1'b1);
    chk("redir_full_valid", {63'd0, bus.o_Valid}, 64'd0);
    chk("redir_full_pc", bus.o_PC, 64'h4);
    cycle(1'b1, 1'b0, 64'h0, 1'b1);
    chk("redir_full_head_pc", bus.o_Instr_PC, 64'h4);
    chk("redir_full_head", {32'd0, bus.o_Instr}, 64'h0051_0113);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = {$urandom, $urandom};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        default: rpc = 64'($urandom_range(0, 15));
      endcase
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
            rpc, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
